// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end types: opcodes, branch prediction record,
// register constants and the PHT initialisation state encoding.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [4:0] RA_REG = 5'd1;
  localparam logic [4:0] T0_REG = 5'd5;

  typedef enum logic [6:0] {
    OP_BRANCH = 7'b1100011,
    OP_JALR   = 7'b1100111,
    OP_JAL    = 7'b1101111
  } opcode_e;

  typedef enum logic {
    PHT_INIT = 1'b0,
    PHT_RUN  = 1'b1
  } pht_init_state_e;

  typedef struct packed {
    logic            predict_taken;
    logic [XLEN-1:0] predict_target;
  } branch_pred_t;

endpackage

// File: rtl/gshare_predictor_if.sv
// Fetch-side prediction and execute-side training signals of the gshare predictor.
interface gshare_predictor_if #(
  parameter int GHR_BITS = 10
);
  import riscv_pkg::*;

  logic                predict_en;
  logic [XLEN-1:0]     pc;
  logic [31:0]         instruction;
  logic                ras_valid;
  logic [XLEN-1:0]     ras_target;
  logic                btb_hit;
  logic [XLEN-1:0]     btb_target;
  branch_pred_t        prediction_out;
  logic [GHR_BITS-1:0] pred_ghr;
  logic                ready;
  logic                update_en;
  logic [XLEN-1:0]     update_pc;
  logic [GHR_BITS-1:0] update_ghr;
  logic                is_branch;
  logic                actual_taken;
  logic                mispredict;

  modport master (
    output predict_en, pc, instruction, ras_valid, ras_target, btb_hit, btb_target,
    output update_en, update_pc, update_ghr, is_branch, actual_taken, mispredict,
    input  prediction_out, pred_ghr, ready
  );

  modport slave (
    input  predict_en, pc, instruction, ras_valid, ras_target, btb_hit, btb_target,
    input  update_en, update_pc, update_ghr, is_branch, actual_taken, mispredict,
    output prediction_out, pred_ghr, ready
  );

endinterface

// File: rtl/pht_ram.sv
// Pattern history table storage: asynchronous read, synchronous write, no reset.
module pht_ram #(
  parameter int ENTRIES  = 1024,
  parameter int CTR_BITS = 2,
  parameter int IDX_W    = $clog2(ENTRIES)
) (
  input  logic                clk,
  input  logic                i_we,
  input  logic [IDX_W-1:0]    i_waddr,
  input  logic [CTR_BITS-1:0] i_wdata,
  input  logic [IDX_W-1:0]    i_raddr,
  output logic [CTR_BITS-1:0] o_rdata
);

  logic [CTR_BITS-1:0] r_mem [ENTRIES];

  // Counter write port
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/gshare_predictor.sv
// Gshare direction predictor with speculative global history, mispredict repair,
// a post-reset PHT sweep and RAS > JAL/JALR > BTB+PHT next-PC priority.
module gshare_predictor
  import riscv_pkg::*;
#(
  parameter int PHT_ENTRIES = 1024,
  parameter int GHR_BITS    = 10,
  parameter int CTR_BITS    = 2
) (
  input logic              clk,
  input logic              reset_n,
  gshare_predictor_if.slave bp
);

  localparam int                  IDX_W    = $clog2(PHT_ENTRIES);
  localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_MAX >> 1;
  localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(PHT_ENTRIES - 1);

  pht_init_state_e     r_state, w_state_next;
  logic [IDX_W-1:0]    r_init_idx;
  logic [GHR_BITS-1:0] r_spec_ghr, w_ghr_next;
  logic [IDX_W-1:0]    w_pred_idx, w_upd_idx, w_waddr;
  logic [CTR_BITS-1:0] w_pred_ctr, w_upd_ctr, w_upd_ctr_next, w_wdata;
  logic                w_we;
  logic [6:0]          w_opcode;
  logic                w_is_jal, w_is_jalr, w_is_branch, w_is_ret;
  branch_pred_t        w_pred;
  logic                w_unused;

  assign w_opcode    = bp.instruction[6:0];
  assign w_is_jal    = (w_opcode == OP_JAL);
  assign w_is_jalr   = (w_opcode == OP_JALR);
  assign w_is_branch = (w_opcode == OP_BRANCH);
  assign w_is_ret    = w_is_jalr && (bp.instruction[11:7] == 5'd0) &&
                       ((bp.instruction[19:15] == RA_REG) || (bp.instruction[19:15] == T0_REG));

  assign w_pred_idx = bp.pc[IDX_W+1:2] ^ IDX_W'(r_spec_ghr);
  assign w_upd_idx  = bp.update_pc[IDX_W+1:2] ^ IDX_W'(bp.update_ghr);

  assign w_unused = ^{bp.instruction[31:20], bp.instruction[14:12],
                      bp.update_pc[XLEN-1:IDX_W+2], bp.update_pc[1:0]};

  // Two replicas with a shared write port give the fetch and training reads their own port
  pht_ram #(.ENTRIES(PHT_ENTRIES), .CTR_BITS(CTR_BITS)) u_pht_pred (
    .clk(clk), .i_we(w_we), .i_waddr(w_waddr), .i_wdata(w_wdata),
    .i_raddr(w_pred_idx), .o_rdata(w_pred_ctr)
  );

  pht_ram #(.ENTRIES(PHT_ENTRIES), .CTR_BITS(CTR_BITS)) u_pht_upd (
    .clk(clk), .i_we(w_we), .i_waddr(w_waddr), .i_wdata(w_wdata),
    .i_raddr(w_upd_idx), .o_rdata(w_upd_ctr)
  );

  // Saturating counter training
  always_comb begin
    w_upd_ctr_next = w_upd_ctr;
    if (bp.actual_taken) begin
      if (w_upd_ctr != CTR_MAX) w_upd_ctr_next = w_upd_ctr + CTR_BITS'(1);
      else                      w_upd_ctr_next = w_upd_ctr;
    end else begin
      if (w_upd_ctr != {CTR_BITS{1'b0}}) w_upd_ctr_next = w_upd_ctr - CTR_BITS'(1);
      else                               w_upd_ctr_next = w_upd_ctr;
    end
  end

  // Write-port mux: the init sweep owns the port until RUN
  always_comb begin
    w_we    = 1'b0;
    w_waddr = r_init_idx;
    w_wdata = CTR_INIT;
    if (r_state == PHT_INIT) begin
      w_we    = 1'b1;
      w_waddr = r_init_idx;
      w_wdata = CTR_INIT;
    end else begin
      w_we    = bp.update_en && bp.is_branch;
      w_waddr = w_upd_idx;
      w_wdata = w_upd_ctr_next;
    end
  end

  // Init-sweep FSM next state
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      PHT_INIT: begin
        if (r_init_idx == IDX_LAST) w_state_next = PHT_RUN;
        else                        w_state_next = PHT_INIT;
      end
      PHT_RUN: w_state_next = PHT_RUN;
      default: w_state_next = PHT_INIT;
    endcase
  end

  // FSM state and sweep index registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= PHT_INIT;
      r_init_idx <= {IDX_W{1'b0}};
    end else begin
      r_state <= w_state_next;
      if (r_state == PHT_INIT) r_init_idx <= r_init_idx + IDX_W'(1);
      else                     r_init_idx <= r_init_idx;
    end
  end

  // Next-PC selection
  always_comb begin
    w_pred = '{predict_taken: 1'b0, predict_target: bp.pc + XLEN'(4)};
    if (bp.predict_en && (r_state == PHT_RUN)) begin
      if (w_is_ret && bp.ras_valid) begin
        w_pred = '{predict_taken: 1'b1, predict_target: bp.ras_target};
      end else if ((w_is_jal || w_is_jalr) && bp.btb_hit) begin
        w_pred = '{predict_taken: 1'b1, predict_target: bp.btb_target};
      end else if (w_is_branch && bp.btb_hit && w_pred_ctr[CTR_BITS-1]) begin
        w_pred = '{predict_taken: 1'b1, predict_target: bp.btb_target};
      end else begin
        w_pred = '{predict_taken: 1'b0, predict_target: bp.pc + XLEN'(4)};
      end
    end else begin
      w_pred = '{predict_taken: 1'b0, predict_target: bp.pc + XLEN'(4)};
    end
  end

  // Speculative history: repair beats the fetch-side shift
  always_comb begin
    w_ghr_next = r_spec_ghr;
    if (r_state != PHT_RUN) begin
      w_ghr_next = {GHR_BITS{1'b0}};
    end else if (bp.update_en && bp.mispredict) begin
      if (bp.is_branch) w_ghr_next = GHR_BITS'({bp.update_ghr, bp.actual_taken});
      else              w_ghr_next = bp.update_ghr;
    end else if (bp.predict_en && w_is_branch) begin
      w_ghr_next = GHR_BITS'({r_spec_ghr, w_pred.predict_taken});
    end else begin
      w_ghr_next = r_spec_ghr;
    end
  end

  // Speculative history register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_spec_ghr <= {GHR_BITS{1'b0}};
    else          r_spec_ghr <= w_ghr_next;
  end

  assign bp.prediction_out = w_pred;
  assign bp.pred_ghr       = r_spec_ghr;
  assign bp.ready          = (r_state == PHT_RUN);

endmodule

// File: tb/tb_gshare_predictor.sv
// Directed bench for gshare_predictor with a per-cycle reference model and literal spot checks.
module tb_gshare_predictor;
  import riscv_pkg::*;

  localparam logic [31:0] I_BEQ = 32'h0000_0063;
  localparam logic [31:0] I_JAL = 32'h0000_006F;
  localparam logic [31:0] I_RET = 32'h0000_8067;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   cycles;

  int m_ctr [1024];
  bit m_ready;
  int m_cnt;
  int m_ghr;

  gshare_predictor_if #(.GHR_BITS(10)) bif ();

  gshare_predictor #(.PHT_ENTRIES(1024), .GHR_BITS(10), .CTR_BITS(2)) dut (
    .clk(clk), .reset_n(reset_n), .bp(bif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [32:0] exp_pred();
    int op, rd, rs1, idx;
    if (!m_ready || !bif.predict_en) return {1'b0, bif.pc + 32'd4};
    op  = int'(bif.instruction & 32'h7F);
    rd  = int'((bif.instruction >> 7) & 32'h1F);
    rs1 = int'((bif.instruction >> 15) & 32'h1F);
    if (op == 'h67 && rd == 0 && (rs1 == 1 || rs1 == 5) && bif.ras_valid)
      return {1'b1, bif.ras_target};
    if ((op == 'h6F || op == 'h67) && bif.btb_hit) return {1'b1, bif.btb_target};
    idx = int'((bif.pc >> 2) & 32'h3FF) ^ m_ghr;
    if (op == 'h63 && bif.btb_hit && m_ctr[idx] >= 2) return {1'b1, bif.btb_target};
    return {1'b0, bif.pc + 32'd4};
  endfunction

  function automatic int upd_idx();
    return int'((bif.update_pc >> 2) & 32'h3FF) ^ int'(bif.update_ghr);
  endfunction

  function automatic int sat(input int c, input logic t);
    if (t) return (c < 3) ? c + 1 : 3;
    return (c > 0) ? c - 1 : 0;
  endfunction

  // Reference model state, following the behavioural rules of the predictor
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_ready <= 1'b0;
      m_cnt   <= 0;
      m_ghr   <= 0;
    end else if (!m_ready) begin
      m_ctr[m_cnt] <= 1;
      m_cnt        <= m_cnt + 1;
      if (m_cnt == 1023) m_ready <= 1'b1;
    end else begin
      if (bif.update_en && bif.is_branch)
        m_ctr[upd_idx()] <= sat(m_ctr[upd_idx()], bif.actual_taken);
      if (bif.update_en && bif.mispredict)
        m_ghr <= bif.is_branch ? (int'(bif.update_ghr) * 2 + int'(bif.actual_taken)) % 1024
                               : int'(bif.update_ghr);
      else if (bif.predict_en && ((bif.instruction & 32'h7F) == 32'h63))
        m_ghr <= (m_ghr * 2 + int'(exp_pred() >> 32)) % 1024;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    chk("pred", {31'd0, bif.prediction_out}, {31'd0, exp_pred()});
    chk("ghr", {54'd0, bif.pred_ghr}, m_ghr);
    chk("ready", {63'd0, bif.ready}, {63'd0, m_ready});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    bif.predict_en = 1'b0; bif.pc = 32'd0; bif.instruction = 32'd0;
    bif.ras_valid = 1'b0; bif.ras_target = 32'd0; bif.btb_hit = 1'b0; bif.btb_target = 32'd0;
    bif.update_en = 1'b0; bif.update_pc = 32'd0; bif.update_ghr = 10'd0;
    bif.is_branch = 1'b0; bif.actual_taken = 1'b0; bif.mispredict = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] pc, input logic [31:0] ins,
                       input logic hit, input logic [31:0] tgt);
    bif.predict_en = 1'b1; bif.pc = pc; bif.instruction = ins;
    bif.btb_hit = hit; bif.btb_target = tgt;
  endtask

  task automatic upd(input logic [31:0] pc, input logic [9:0] ghr, input logic taken,
                     input logic misp, input logic isbr);
    bif.update_en = 1'b1; bif.update_pc = pc; bif.update_ghr = ghr;
    bif.actual_taken = taken; bif.mispredict = misp; bif.is_branch = isbr;
  endtask

  task automatic set_ghr(input logic [9:0] g);
    clear_in(); upd(32'h0, g, 1'b0, 1'b1, 1'b0); tick(); clear_in();
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!bif.ready && n < 2000) begin
      tick();
      n++;
    end
  endtask

  initial begin
    clear_in();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // 1: sweep length and first prediction
    chk("ready_in_init", {63'd0, bif.ready}, 64'd0);
    wait_ready(cycles);
    chk("init_cycles", cycles, 64'd1024);
    fetch(32'h100, I_BEQ, 1'b1, 32'h200);
    #1 chk("s1_weak_nt", {31'd0, bif.prediction_out}, {31'd0, 1'b0, 32'h104});
    tick(); clear_in();

    // 2: two taken trainings flip the entry to taken
    upd(32'h100, 10'd0, 1'b1, 1'b0, 1'b1); tick(); tick(); clear_in();
    fetch(32'h100, I_BEQ, 1'b1, 32'h200);
    #1 chk("s2_taken", {31'd0, bif.prediction_out}, {31'd0, 1'b1, 32'h200});
    tick();
    chk("s2_ghr_shift", {54'd0, bif.pred_ghr}, 64'h1);
    set_ghr(10'd0);

    // 3: saturation at 3
    upd(32'h100, 10'd0, 1'b1, 1'b0, 1'b1); repeat (4) tick();
    upd(32'h100, 10'd0, 1'b0, 1'b0, 1'b1); tick(); clear_in();
    fetch(32'h100, I_BEQ, 1'b1, 32'h200);
    #1 chk("s3_sat_taken", {31'd0, bif.prediction_out}, {31'd0, 1'b1, 32'h200});
    clear_in();
    upd(32'h100, 10'd0, 1'b0, 1'b0, 1'b1); tick(); clear_in();
    fetch(32'h100, I_BEQ, 1'b1, 32'h200);
    #1 chk("s3_nt", {31'd0, bif.prediction_out}, {31'd0, 1'b0, 32'h104});
    clear_in();

    // 4: untrained branches keep history at 0, repair beats the shift
    for (int i = 0; i < 3; i++) begin
      fetch(32'h300 + 32'(i * 4), I_BEQ, 1'b0, 32'h0); tick();
      chk("s4_ghr_zero", {54'd0, bif.pred_ghr}, 64'h0);
    end
    fetch(32'h30C, I_BEQ, 1'b1, 32'h200);
    upd(32'h400, 10'h005, 1'b1, 1'b1, 1'b1);
    tick(); clear_in();
    chk("s4_repair", {54'd0, bif.pred_ghr}, 64'h00B);

    // 5: priority
    fetch(32'h500, I_RET, 1'b1, 32'h5678);
    bif.ras_valid = 1'b1; bif.ras_target = 32'h1234;
    #1 chk("s5_ras", {31'd0, bif.prediction_out}, {31'd0, 1'b1, 32'h1234});
    fetch(32'h504, I_JAL, 1'b1, 32'h5678);
    bif.ras_valid = 1'b0;
    #1 chk("s5_jal", {31'd0, bif.prediction_out}, {31'd0, 1'b1, 32'h5678});
    bif.predict_en = 1'b0;
    #1 chk("s5_noen", {31'd0, bif.prediction_out}, {31'd0, 1'b0, 32'h508});
    tick(); clear_in();

    // 6: asynchronous reset mid-run clears trained state via the sweep
    set_ghr(10'd0);
    upd(32'h100, 10'd0, 1'b1, 1'b0, 1'b1); tick(); tick(); clear_in();
    fetch(32'h100, I_BEQ, 1'b1, 32'h200);
    #1 chk("s6_pre_taken", {31'd0, bif.prediction_out}, {31'd0, 1'b1, 32'h200});
    clear_in();
    #1 reset_n = 1'b0;
    #1 chk("s6_async_drop", {63'd0, bif.ready}, 64'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    upd(32'h100, 10'h3FF, 1'b1, 1'b1, 1'b1); tick(); clear_in();
    chk("s6_init_drop", {54'd0, bif.pred_ghr}, 64'h0);
    wait_ready(cycles);
    chk("s6_ready", {63'd0, bif.ready}, 64'd1);
    fetch(32'h100, I_BEQ, 1'b1, 32'h200);
    #1 chk("s6_post_nt", {31'd0, bif.prediction_out}, {31'd0, 1'b0, 32'h104});
    tick(); clear_in();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
